// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled start/data/parity/stop decoding feeding a
// small first-word-fall-through FIFO of {frame_err, parity_err, data} entries.
module uart_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bclk,
    input  logic       rxd,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       rx_en,
    input  logic       read_en,
    input  logic [1:0] rx_thr_val,
    output logic [7:0] data_out,
    output logic       rx_rdy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_thr,
    output logic       rx_bclk_en
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  HALF_C    = CNT_W'(FIFO_DEPTH / 2 + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic parity_expected(input logic [7:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

    logic              rxd_meta_q;
    logic              rxd_s_q;
    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              par_err_q, par_err_d;
    logic              push_s;
    logic [9:0]        push_word_s;

    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overrun_q;
    logic              pop_s;
    logic              full_s;
    logic              wr_ok_s;
    logic [9:0]        head_s;

    // Two-flop synchroniser on the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Frame decoder state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= 3'd0;
            data_q    <= 8'd0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_err_q <= par_err_d;
        end
    end

    // Frame decoder next-state logic; every sample point is one full bit after the start mid-bit.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        data_d      = data_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        par_err_d   = par_err_q;
        push_s      = 1'b0;
        push_word_s = {~rxd_s_q, par_err_q, data_q};

        if ((state_q != ST_IDLE) && !rx_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bclk && rx_en && !rxd_s_q) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bclk) begin
                        if (tick_q == TICK_MID) begin
                            if (rxd_s_q) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d   = ST_DATA;
                                tick_d    = '0;
                                bit_d     = 3'd0;
                                data_d    = 8'd0;
                                par_err_d = 1'b0;
                                par_en_d  = parity_en;
                                par_odd_d = parity_type;
                            end
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end else begin
                        tick_d = tick_q;
                    end
                end
                ST_DATA: begin
                    if (bclk) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d        = '0;
                            data_d[bit_q] = rxd_s_q;
                            if (bit_q == 3'd7) begin
                                state_d = par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end else begin
                        tick_d = tick_q;
                    end
                end
                ST_PARITY: begin
                    if (bclk) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d    = '0;
                            par_err_d = (rxd_s_q != parity_expected(data_q, par_odd_q));
                            state_d   = ST_STOP;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end else begin
                        tick_d = tick_q;
                    end
                end
                ST_STOP: begin
                    if (bclk) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d  = '0;
                            push_s  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end else begin
                        tick_d = tick_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pop_s   = read_en && (count_q != '0);
    assign full_s  = (count_q == DEPTH_C);
    // A pop in the same clk frees the slot, so a full FIFO still accepts the push.
    assign wr_ok_s = push_s && (!full_s || pop_s);

    // Receive FIFO storage, pointers, occupancy and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                mem_q[wr_ptr_q] <= push_word_s;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_ok_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (pop_s) begin
                overrun_q <= 1'b0;
            end else if (push_s && full_s) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign head_s      = mem_q[rd_ptr_q];
    assign rx_rdy      = (count_q != '0);
    assign data_out    = rx_rdy ? head_s[7:0] : 8'd0;
    assign parity_err  = rx_rdy ? head_s[8]   : 1'b0;
    assign frame_err   = rx_rdy ? head_s[9]   : 1'b0;
    assign overrun_err = overrun_q;
    assign rx_bclk_en  = (state_q != ST_IDLE);

    // FIFO level threshold comparator.
    always_comb begin
        rx_thr = 1'b0;
        case (rx_thr_val)
            2'b00:   rx_thr = (count_q >= CNT_W'(1));
            2'b01:   rx_thr = (count_q >= CNT_W'(2));
            2'b10:   rx_thr = (count_q >= HALF_C);
            2'b11:   rx_thr = (count_q == DEPTH_C);
            default: rx_thr = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: parity, framing, glitch,
// FIFO fill/overrun/threshold, rx_en abort and mid-frame reset.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       bclk = 1'b0;
    logic       rxd;
    logic       parity_en;
    logic       parity_type;
    logic       rx_en;
    logic       read_en;
    logic [1:0] rx_thr_val;
    logic [7:0] data_out;
    logic       rx_rdy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_thr;
    logic       rx_bclk_en;

    int checks = 0;
    int errors = 0;
    int div    = 0;

    uart_receiver #(.FIFO_DEPTH(4), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bclk        (bclk),
        .rxd         (rxd),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .rx_en       (rx_en),
        .read_en     (read_en),
        .rx_thr_val  (rx_thr_val),
        .data_out    (data_out),
        .rx_rdy      (rx_rdy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_thr      (rx_thr),
        .rx_bclk_en  (rx_bclk_en)
    );

    always #5 clk = ~clk;

    // One-clk bclk tick every fourth clk.
    always @(negedge clk) begin
        div  = (div == 3) ? 0 : div + 1;
        bclk = (div == 0);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (bclk !== 1'b1);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        wait_tick();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        rxd = 1'b1;
        wait_ticks(20);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pop();
        @(posedge clk);
        #1 read_en = 1'b1;
        @(posedge clk);
        #1 read_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxd = 1'b1; parity_en = 1'b1; parity_type = 1'b0;
        rx_en = 1'b1; read_en = 1'b0; rx_thr_val = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_rdy", {7'd0, rx_rdy}, 8'd0);
        check("rst_data", data_out, 8'h00);
        check("rst_flags", {3'd0, parity_err, frame_err, overrun_err, rx_thr, rx_bclk_en}, 8'd0);

        // Even parity, 8'hA4 has three ones so the parity bit is 1.
        send_frame(8'hA4, 1'b1, 1'b1, 1'b1);
        check("even_rdy", {7'd0, rx_rdy}, 8'd1);
        check("even_data", data_out, 8'hA4);
        check("even_perr", {7'd0, parity_err}, 8'd0);
        check("even_ferr", {7'd0, frame_err}, 8'd0);
        check("even_bclk_en", {7'd0, rx_bclk_en}, 8'd0);
        check("even_thr00", {7'd0, rx_thr}, 8'd1);
        pop();
        check("even_pop_rdy", {7'd0, rx_rdy}, 8'd0);

        send_frame(8'hA4, 1'b1, 1'b0, 1'b1);
        check("bad_par_data", data_out, 8'hA4);
        check("bad_par_perr", {7'd0, parity_err}, 8'd1);
        check("bad_par_ferr", {7'd0, frame_err}, 8'd0);
        pop();

        parity_type = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
        check("odd_data", data_out, 8'h0F);
        check("odd_perr", {7'd0, parity_err}, 8'd0);
        pop();

        parity_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("ferr_data", data_out, 8'h3C);
        check("ferr_flag", {7'd0, frame_err}, 8'd1);
        check("ferr_perr", {7'd0, parity_err}, 8'd0);
        pop();
        check("ferr_pop_rdy", {7'd0, rx_rdy}, 8'd0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check("after_ferr_data", data_out, 8'h55);
        check("after_ferr_flag", {7'd0, frame_err}, 8'd0);
        pop();
        check("after_ferr_pop_rdy", {7'd0, rx_rdy}, 8'd0);

        // Short low glitch is rejected at the start mid-bit.
        wait_tick();
        rxd = 1'b0;
        wait_ticks(4);
        check("glitch_bclk_en_busy", {7'd0, rx_bclk_en}, 8'd1);
        rxd = 1'b1;
        wait_ticks(12);
        check("glitch_bclk_en_idle", {7'd0, rx_bclk_en}, 8'd0);
        check("glitch_rdy", {7'd0, rx_rdy}, 8'd0);

        // Fill the FIFO and overflow it.
        rx_thr_val = 2'b11;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        rx_thr_val = 2'b10;
        #1 check("thr10_cnt2", {7'd0, rx_thr}, 8'd0);
        rx_thr_val = 2'b01;
        #1 check("thr01_cnt2", {7'd0, rx_thr}, 8'd1);
        rx_thr_val = 2'b11;
        send_frame(8'h03, 1'b0, 1'b0, 1'b1);
        check("thr11_cnt3", {7'd0, rx_thr}, 8'd0);
        rx_thr_val = 2'b10;
        #1 check("thr10_cnt3", {7'd0, rx_thr}, 8'd1);
        rx_thr_val = 2'b11;
        send_frame(8'h04, 1'b0, 1'b0, 1'b1);
        check("thr11_cnt4", {7'd0, rx_thr}, 8'd1);
        check("full_ovr", {7'd0, overrun_err}, 8'd0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        check("ovr_set", {7'd0, overrun_err}, 8'd1);
        check("ovr_head", data_out, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check("fifo_order", data_out, 8'(i));
            pop();
            check("ovr_clear", {7'd0, overrun_err}, 8'd0);
        end
        check("drain_rdy", {7'd0, rx_rdy}, 8'd0);
        check("drain_thr", {7'd0, rx_thr}, 8'd0);

        // rx_en abort mid-DATA keeps the FIFO contents.
        rx_thr_val = 2'b00;
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        wait_tick();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        check("abort_busy", {7'd0, rx_bclk_en}, 8'd1);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_bclk_en", {7'd0, rx_bclk_en}, 8'd0);
        check("abort_rdy", {7'd0, rx_rdy}, 8'd1);
        check("abort_keep", data_out, 8'h99);
        rxd = 1'b1;
        wait_ticks(20);
        check("abort_no_push_keep", data_out, 8'h99);
        rx_en = 1'b1;
        wait_tick();
        rxd = 1'b0;
        wait_ticks(6);
        check("mid_busy", {7'd0, rx_bclk_en}, 8'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rxd = 1'b1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_flags", {2'd0, rx_rdy, parity_err, frame_err, overrun_err, rx_thr, rx_bclk_en}, 8'd0);
        wait_ticks(20);
        check("mid_rst_idle", {7'd0, rx_rdy}, 8'd0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check("final_rdy", {7'd0, rx_rdy}, 8'd1);
        check("final_data", data_out, 8'hC3);
        check("final_flags", {6'd0, parity_err, frame_err}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive half of the UART; pairs with uart_transmitter on the same baud tick and line format.
- Oversamples serial input rxd at 16x using the bclk tick.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Decoded bytes and their per-frame error flags go into a small first-word-fall-through FIFO, read by the bus-side interrupt/register logic.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, min 2).
- OVERSAMPLE, 16, bclk ticks per bit (fixed at 16; parameter exists for documentation and counter width).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- bclk  input  1  one-clk-wide 16x baud tick enable, clk domain
- rxd  input  1  serial line, idle high, asynchronous
- parity_en  input  1  1 = parity bit expected after data
- parity_type  input  1  0 = even, 1 = odd
- rx_en  input  1  receiver enable
- read_en  input  1  pop FIFO head (one clk pulse)
- rx_thr_val  input  2  FIFO threshold select
- data_out  output  8  FIFO head data
- rx_rdy  output  1  FIFO not empty
- parity_err  output  1  parity error flag of FIFO head
- frame_err  output  1  stop-bit error flag of FIFO head
- overrun_err  output  1  sticky overrun flag
- rx_thr  output  1  FIFO level >= threshold
- rx_bclk_en  output  1  high while a frame is in progress (requests baud generator)

Behaviour:
- Reset (reset=1 at posedge clk):
  - state IDLE, FIFO empty, synchroniser flops = 1.
  - data_out=0, rx_rdy=0, parity_err=0, frame_err=0, overrun_err=0, rx_thr=0, rx_bclk_en=0.
- Synchroniser: 2-flop sync on rxd gives rxd_s. All decisions use rxd_s.
- Counters: tick counter 0..15 advances only on bclk. Bit counter 0..7.
- FSM states:
  - IDLE: on rxd_s=0 at a bclk tick with rx_en=1, go START and clear the tick counter. rx_bclk_en=0 only in IDLE.
  - START: at tick count 7 (mid-bit), if rxd_s=1 the start is false; return to IDLE with no push. Otherwise clear the tick counter and go DATA.
  - DATA: sample rxd_s at tick count 15 (the next mid-bit) and shift into bit [bit counter], LSB first. After bit 7, go PARITY if parity_en=1, else STOP.
  - PARITY: sample at count 15.
    - Expected bit = ^data for even, ~^data for odd. Example: 8'hA4 with even parity expects 1.
    - Mismatch sets the frame's parity flag.
  - STOP: sample at count 15. rxd_s=0 sets the frame's frame_err flag. Push {frame_err, parity_err, data} into the FIFO in the same clk, then go IDLE.
  - A frame with frame_err=1 is still pushed. IDLE re-arms immediately; if the line is still low, a new start is detected on the next tick.
- parity_en and parity_type are sampled at the START→DATA transition and held for the frame.
- rx_en deasserted mid-frame: return to IDLE on the next clk, discard the partial frame, no push. FIFO contents are retained.
- FIFO:
  - First-word fall-through. data_out, parity_err and frame_err show the head entry whenever rx_rdy=1. They are 0 when empty.
  - read_en with rx_rdy=1 pops one entry, and the next head is visible on the following clk.
  - read_en while empty is ignored.
  - Push while full with no pop in the same clk: new frame dropped, overrun_err set. Existing entries are unchanged.
  - Push and pop in the same clk when full: both occur, no overrun.
  - Push and pop in the same clk when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- overrun_err: sticky. Cleared on the clk after a read_en pop, or by reset.
- rx_thr: combinational from count.
  - rx_thr_val 00 → count>=1, 01 → count>=2, 10 → count>=FIFO_DEPTH/2+1, 11 → count==FIFO_DEPTH.
- Latency: data is visible at data_out 1 clk after the STOP sampling tick.

Test Plan:
- Reset, rx_en=1, parity_en=1 even. Drive frame 8'hA4 + parity 1 + stop 1 at 16 bclk per bit. Expect rx_rdy=1, data_out=8'hA4, parity_err=0, frame_err=0, rx_bclk_en low after the stop bit.
- Same frame with parity bit 0 → parity_err=1, data_out=8'hA4. Odd parity with 8'h0F and parity bit 1 → no error.
- parity_en=0, frame 8'h3C with stop bit 0 → frame_err=1, data_out=8'h3C. Following frame 8'h55 with a good stop is received correctly.
- Low glitch on rxd for 4 bclk ticks in IDLE → no push, FSM back in IDLE, rx_bclk_en drops.
- Send 5 frames (8'h01..8'h05) without reading, FIFO_DEPTH=4.
  - rx_thr with val=11 asserts after the 4th frame.
  - overrun_err=1 after the 5th; the FIFO holds 01..04.
  - Pop 4 times → 01,02,03,04 in order. overrun_err clears after the first pop. rx_rdy=0 at the end.
- Deassert rx_en mid-DATA, then assert reset mid-frame → no push, all outputs 0 after reset. Re-enable and receive 8'hC3 correctly.
